// File: rtl/div_hilo_controller.sv
// DIV/DIVU sequencer for the execute stage.
// Owns HI/LO and runs a radix-2 restoring divide, one quotient bit per cycle.
// Stalls MFHI/MFLO or a new divide while a result is still in flight.
module div_hilo_controller #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             rd_hi,
    input  logic             rd_lo,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StPrep, StIter, StFixup} state_e;

    state_e           state_q, state_d;
    // quo holds the dividend until PREP, then its magnitude, then the quotient
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    // dvs holds the raw divisor until PREP, then its magnitude
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, diff;

    // Next-state, datapath step and fast-path decisions
    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        a_neg  = sgn_q & quo_q[WIDTH-1];
        b_neg  = sgn_q & dvs_q[WIDTH-1];
        a_mag  = a_neg ? -quo_q : quo_q;
        b_mag  = b_neg ? -dvs_q : dvs_q;
        // Shift next dividend bit into the partial remainder, trial-subtract in WIDTH+1 bits
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d = StPrep;
                    quo_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = is_signed;
                end
            end
            StPrep: begin
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
                rem_d  = '0;
                cnt_d  = CW'(WIDTH - 1);
                if (dvs_q == '0) begin
                    // Divide by zero: all-ones quotient, raw dividend as remainder
                    quo_d   = '1;
                    rem_d   = quo_q;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    state_d = StFixup;
                end else if (sgn_q && (quo_q == MinNeg) && (dvs_q == '1)) begin
                    // Signed overflow: quotient wraps to the dividend, remainder zero
                    quo_d   = quo_q;
                    rem_d   = '0;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    state_d = StFixup;
                end else begin
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    state_d = StIter;
                end
            end
            StIter: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                lo_d    = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
        endcase

        // Squash abandons the divide without touching HI/LO
        if (flush && (state_q != StIdle)) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs; stall is low in the done cycle so a waiting reader sees the new value
    always_comb begin
        busy  = (state_q != StIdle);
        stall = busy & (rd_hi | rd_lo | start);
        done  = done_q;
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule
